// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
//   Byte-addressable data memory for the single-cycle MIPS datapath. The ALU
//   result is the effective address and rt is the store data. Stores write a
//   word, half or byte and merge it into the selected byte lanes. Loads read
//   combinationally and sign- or zero-extend a half or byte.
//
//   Optional feature, macro DM_ALIGN_CHECK_EN:
//     defined   - Misalign flags word accesses with addr[1:0]!=0 and half
//                 accesses with addr[0]=1. A misaligned store is dropped and
//                 a misaligned load returns zero.
//     undefined - Misalign is tied to 0. The low address bits below the
//                 access size are ignored, so every access is aligned.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset, clears every word
//   MemWrite  in   1   store enable
//   DMType    in   3   000 word, 001 hu, 010 h, 011 bu, 100 b, others word
//   addr      in  32   byte address, word index addr[AW+1:2], upper bits wrap
//   din       in  32   store data
//   dout      out 32   extended load data (zero latency)
//   Misalign  out  1   misaligned access flag
// ---------------------------------------------------------------------------
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [2:0]  DMType,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        Misalign
);

  localparam logic [2:0] DM_HU = 3'b001;
  localparam logic [2:0] DM_HS = 3'b010;
  localparam logic [2:0] DM_BU = 3'b011;
  localparam logic [2:0] DM_BS = 3'b100;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          is_half;
  logic          is_byte;
  logic          misal;
  logic          wr_en;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [15:0]   rhalf;
  logic [7:0]    rbyte;

  // Address bits above the array size are wrapped away on purpose.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'h0000, h};
  endfunction

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'h000000, b};
  endfunction

  assign widx    = addr[AW+1:2];
  assign is_half = (DMType == DM_HU) || (DMType == DM_HS);
  assign is_byte = (DMType == DM_BU) || (DMType == DM_BS);

`ifdef DM_ALIGN_CHECK_EN
  // Reserved encodings fall into the word branch.
  assign misal = (!is_half && !is_byte && (addr[1:0] != 2'b00)) ||
                 (is_half && addr[0]);
`else
  assign misal = 1'b0;
`endif

  assign Misalign = misal;
  assign wr_en    = MemWrite && !misal;

  // Lane enables and lane-replicated store data: replicating the half/byte
  // across the word lets each lane simply take its own slice of wdata.
  always_comb begin
    be    = 4'hF;
    wdata = din;
    if (is_half) begin
      be    = addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{din[15:0]}};
    end else if (is_byte) begin
      be    = 4'b0001 << addr[1:0];
      wdata = {4{din[7:0]}};
    end
  end

  // Reset wins over a same-cycle store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Combinational read of pre-edge contents; no write bypass.
  assign rword = mem_q[widx];
  assign rhalf = addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (addr[1:0])
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
  end

  always_comb begin
    if (misal) begin
      dout = 32'h0000_0000;
    end else begin
      case (DMType)
        DM_HU:   dout = ext_half(rhalf, 1'b0);
        DM_HS:   dout = ext_half(rhalf, 1'b1);
        DM_BU:   dout = ext_byte(rbyte, 1'b0);
        DM_BS:   dout = ext_byte(rbyte, 1'b1);
        default: dout = rword;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  localparam int DEPTH = 1024;
  localparam int NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic [2:0]  DMType;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        Misalign;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Reference memory kept as a flat little-endian byte array.
  logic [7:0] mb [NB];

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_WORDS(DEPTH), .AW(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .MemWrite (MemWrite),
    .DMType   (DMType),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .Misalign (Misalign)
  );

  function automatic bit m_half(input logic [2:0] t);
    return (t == 3'd1) || (t == 3'd2);
  endfunction

  function automatic bit m_byte(input logic [2:0] t);
    return (t == 3'd3) || (t == 3'd4);
  endfunction

  function automatic bit m_mis(input logic [2:0] t, input logic [31:0] a);
`ifdef DM_ALIGN_CHECK_EN
    if (m_byte(t)) return 1'b0;
    if (m_half(t)) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] t, input logic [31:0] a);
    int unsigned ba;
    int unsigned base;
    logic [15:0] h;
    logic [7:0]  b;
    ba = a % NB;
    if (m_mis(t, a)) return 32'h0;
    if (m_half(t)) begin
      base = ba - (ba % 2);
      h = {mb[base+1], mb[base]};
      return (t == 3'd2) ? {{16{h[15]}}, h} : {16'h0, h};
    end
    if (m_byte(t)) begin
      b = mb[ba];
      return (t == 3'd4) ? {{24{b[7]}}, b} : {24'h0, b};
    end
    base = ba - (ba % 4);
    return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
  endfunction

  // Apply the effect of the edge that has just occurred.
  task automatic m_commit();
    int unsigned ba;
    int unsigned base;
    ba = addr % NB;
    if (rst) begin
      for (int i = 0; i < NB; i++) mb[i] = 8'h00;
    end else if (MemWrite && !m_mis(DMType, addr)) begin
      if (m_half(DMType)) begin
        base = ba - (ba % 2);
        mb[base]   = din[7:0];
        mb[base+1] = din[15:8];
      end else if (m_byte(DMType)) begin
        mb[ba] = din[7:0];
      end else begin
        base = ba - (ba % 4);
        mb[base]   = din[7:0];
        mb[base+1] = din[15:8];
        mb[base+2] = din[23:16];
        mb[base+3] = din[31:24];
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t addr=%h DMType=%0d)",
               nm, act, exp, $time, addr, DMType);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle with stable inputs.
  always @(negedge clk) begin
    if (armed) begin
      chk("dout_model", dout, m_read(DMType, addr));
      chk("misalign_model", {31'b0, Misalign}, {31'b0, m_mis(DMType, addr)});
    end
  end

  task automatic step(input bit r, input bit we, input logic [2:0] t,
                      input logic [31:0] a, input logic [31:0] d);
    rst = r; MemWrite = we; DMType = t; addr = a; din = d;
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic peek(input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] exp, input string nm);
    rst = 1'b0; MemWrite = 1'b0; DMType = t; addr = a; din = 32'h0;
    #1;
    chk(nm, dout, exp);
    @(posedge clk);
    m_commit();
    #1;
  endtask

  initial begin
    rst = 1'b1; MemWrite = 1'b0; DMType = 3'd0; addr = 32'h0; din = 32'h0;
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    armed = 1'b1;

    // Load extension on a known word
    step(1'b0, 1'b1, 3'd0, 32'h10, 32'h8899AABB);
    peek(3'd4, 32'h10, 32'hFFFFFFBB, "lb_0x10");
    peek(3'd3, 32'h13, 32'h00000088, "lbu_0x13");
    peek(3'd2, 32'h12, 32'hFFFF8899, "lh_0x12");
    peek(3'd1, 32'h10, 32'h0000AABB, "lhu_0x10");

    // Byte/half merges accumulating in back-to-back cycles
    step(1'b0, 1'b1, 3'd0, 32'h20, 32'h11223344);
    step(1'b0, 1'b1, 3'd3, 32'h21, 32'h000000EE);
    peek(3'd0, 32'h20, 32'h1122EE44, "sb_merge");
    step(1'b0, 1'b1, 3'd1, 32'h22, 32'h00005566);
    step(1'b0, 1'b1, 3'd4, 32'h23, 32'h00000077);
    peek(3'd0, 32'h20, 32'h7766EE44, "sh_sb_merge");

    // No bypass: the read before the edge still sees the old word
    rst = 1'b0; MemWrite = 1'b1; DMType = 3'd0; addr = 32'h20; din = 32'h01020304;
    #1;
    chk("no_bypass", dout, 32'h7766EE44);
    @(posedge clk); m_commit(); #1;
    peek(3'd0, 32'h20, 32'h01020304, "after_write");

    // Reset wins over a simultaneous store
    step(1'b1, 1'b1, 3'd0, 32'h8, 32'hDEADBEEF);
    peek(3'd0, 32'h8, 32'h00000000, "rst_over_write");

    // Address wrap and reserved DMType
    step(1'b0, 1'b1, 3'd0, 32'h1000, 32'hCAFEF00D);
    peek(3'd0, 32'h0, 32'hCAFEF00D, "wrap_lw0");
    peek(3'd7, 32'h0, 32'hCAFEF00D, "reserved_as_word");

    // Randomised traffic, mostly in a small window so accesses collide
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h7F);
      if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), a, $urandom);
    end

    // Reset after random traffic
    step(1'b0, 1'b1, 3'd0, 32'hFFC, 32'h13572468);
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
    peek(3'd0, 32'h0,   32'h0, "rst_lw_0x0");
    peek(3'd0, 32'h4,   32'h0, "rst_lw_0x4");
    peek(3'd0, 32'hFFC, 32'h0, "rst_lw_0xFFC");

    // Misaligned word store at 0x6
    step(1'b0, 1'b1, 3'd0, 32'h4, 32'h0BADF00D);
    rst = 1'b0; MemWrite = 1'b1; DMType = 3'd0; addr = 32'h6; din = 32'h12345678;
    #1;
`ifdef DM_ALIGN_CHECK_EN
    chk("misalign_sw6", {31'b0, Misalign}, 32'h1);
`else
    chk("misalign_sw6", {31'b0, Misalign}, 32'h0);
`endif
    @(posedge clk); m_commit(); #1;
`ifdef DM_ALIGN_CHECK_EN
    peek(3'd0, 32'h4, 32'h0BADF00D, "mis_sw_suppressed");
    peek(3'd0, 32'h6, 32'h00000000, "mis_lw_zero");
`else
    peek(3'd0, 32'h4, 32'h12345678, "mis_sw_aligned");
    peek(3'd0, 32'h6, 32'h12345678, "mis_lw_aligned");
    peek(3'd2, 32'h7, 32'h00001234, "mis_lh_aligned");
`endif

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
